// File: rtl/buffer_pkg.sv
// Shared defaults and index/data types for the packet output buffer.
package buffer_pkg;
  localparam int NUM_SLOTS_D = 4;
  localparam int DEPTH_D     = 16;
  localparam int DATA_W_D    = 8;
  localparam int LEN_W_D     = $clog2(DEPTH_D + 1);
  localparam int SLOT_W_D    = $clog2(NUM_SLOTS_D);
  localparam int WORD_W_D    = $clog2(DEPTH_D);

  typedef logic [SLOT_W_D-1:0] slot_idx_t;
  typedef logic [WORD_W_D-1:0] word_idx_t;
  typedef logic [LEN_W_D-1:0]  len_t;
  typedef logic [DATA_W_D-1:0] data_t;
endpackage

// File: rtl/buffer_slot_mem.sv
// Packet slot storage: NUM_SLOTS x DEPTH words plus a resettable length per slot.
module buffer_slot_mem
  import buffer_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_D,
  parameter int DEPTH     = DEPTH_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_clr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_clr_slot,
  input  logic                         i_wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_wr_slot,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_rd_slot,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic [LEN_W-1:0]             o_rd_len,
  output logic [LEN_W-1:0]             o_wr_len
);
  logic [DATA_W-1:0] r_mem [NUM_SLOTS][DEPTH];
  logic [LEN_W-1:0]  r_len [NUM_SLOTS];
  logic [LEN_W-1:0]  w_wr_top;

  assign w_wr_top = LEN_W'(i_wr_addr) + LEN_W'(1);

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_slot][i_wr_addr] <= i_wr_data;
  end

  // Length tracks the highest index written plus one; opening a slot clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_len[i] <= '0;
    end else begin
      if (i_clr_en) r_len[i_clr_slot] <= '0;
      if (i_wr_en && (w_wr_top > r_len[i_wr_slot])) r_len[i_wr_slot] <= w_wr_top;
    end
  end

  assign o_rd_data = r_mem[i_rd_slot][i_rd_addr];
  assign o_rd_len  = r_len[i_rd_slot];
  assign o_wr_len  = r_len[i_wr_slot];
endmodule

// File: rtl/out_buffer_cntr.sv
// Packet-oriented output FIFO: ring of slots opened by the writer, drained in order by the reader.
module out_buffer_cntr
  import buffer_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_D,
  parameter int DEPTH     = DEPTH_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_port,
  output logic                     done_port,
  input  logic                     wr_next,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [LEN_W-1:0]         wr_len,
  input  logic                     rd_next,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [LEN_W-1:0]         rd_len,
  output logic                     full,
  output logic                     empty
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);

  logic [SW-1:0] r_wr_ptr, r_wr_slot, r_rd_ptr, r_rd_slot;
  logic          r_wr_valid, r_rd_valid;
  logic [CW-1:0] r_occ, r_pend;
  logic          w_rd_go, w_free, w_wr_go, w_wr_en;
  logic [CW-1:0] w_occ_adj;
  logic [DATA_W-1:0] w_rd_data;
  logic [LEN_W-1:0]  w_rd_len, w_wr_len;

  // The slot freed by a same-cycle rd_next counts toward room for a new open.
  assign w_rd_go   = start_port & rd_next & (r_pend != '0);
  assign w_free    = w_rd_go & r_rd_valid;
  assign w_occ_adj = r_occ - CW'(w_free);
  assign w_wr_go   = start_port & wr_next & (w_occ_adj != FULL_CNT);
  assign w_wr_en   = start_port & wr_en & r_wr_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_wr_slot  <= '0;
      r_wr_valid <= 1'b0;
      r_rd_ptr   <= '0;
      r_rd_slot  <= '0;
      r_rd_valid <= 1'b0;
      r_occ      <= '0;
      r_pend     <= '0;
    end else begin
      if (w_wr_go) begin
        r_wr_slot  <= r_wr_ptr;
        r_wr_ptr   <= r_wr_ptr + SW'(1);
        r_wr_valid <= 1'b1;
      end
      if (w_rd_go) begin
        r_rd_slot  <= r_rd_ptr;
        r_rd_ptr   <= r_rd_ptr + SW'(1);
        r_rd_valid <= 1'b1;
      end
      r_occ  <= w_occ_adj + CW'(w_wr_go);
      r_pend <= r_pend + CW'(w_wr_go) - CW'(w_rd_go);
    end
  end

  buffer_slot_mem #(
    .NUM_SLOTS(NUM_SLOTS),
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .i_clr_en  (w_wr_go),
    .i_clr_slot(r_wr_ptr),
    .i_wr_en   (w_wr_en),
    .i_wr_slot (r_wr_slot),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_slot (r_rd_slot),
    .i_rd_addr (rd_addr),
    .o_rd_data (w_rd_data),
    .o_rd_len  (w_rd_len),
    .o_wr_len  (w_wr_len)
  );

  assign wr_len    = r_wr_valid ? w_wr_len : '0;
  assign rd_len    = r_rd_valid ? w_rd_len : '0;
  assign rd_data   = r_rd_valid ? w_rd_data : '0;
  assign done_port = (r_pend == '0);
  assign full      = (r_occ == FULL_CNT);
  assign empty     = (r_occ == '0);
endmodule

// File: tb/tb_out_buffer_cntr.sv
// Directed plus randomized bench for out_buffer_cntr against a queue-based packet model.
module tb_out_buffer_cntr;
  localparam int NS = 4;
  localparam int DP = 16;

  logic       clock = 1'b0;
  logic       reset, start_port, done_port;
  logic       wr_next, wr_en, rd_next;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [4:0] wr_len, rd_len;
  logic       full, empty;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: opened-but-unselected slots in a queue, per-slot contents.
  int pend_q[$];
  int occ, sel, wslot, nxt;
  int mlen [NS];
  int mdata [NS][DP];
  bit known [NS][DP];

  always #10 clock = ~clock;

  out_buffer_cntr dut (
    .clock     (clock),
    .reset     (reset),
    .start_port(start_port),
    .done_port (done_port),
    .wr_next   (wr_next),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_len    (wr_len),
    .rd_next   (rd_next),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_len    (rd_len),
    .full      (full),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    occ = 0; sel = -1; wslot = -1; nxt = 0;
    for (int s = 0; s < NS; s++) begin
      mlen[s] = 0;
      for (int j = 0; j < DP; j++) known[s][j] = 1'b0;
    end
  endtask

  task automatic tick();
    bit rd_go, fr, wr_go, we;
    int a;
    rd_go = start_port && rd_next && (pend_q.size() > 0);
    fr    = rd_go && (sel >= 0);
    wr_go = start_port && wr_next && ((occ - int'(fr)) < NS);
    we    = start_port && wr_en && (wslot >= 0);
    if (we) begin
      a = int'(wr_addr);
      mdata[wslot][a] = int'(wr_data);
      known[wslot][a] = 1'b1;
      if (a + 1 > mlen[wslot]) mlen[wslot] = a + 1;
    end
    if (rd_go) begin
      if (fr) occ--;
      sel = pend_q.pop_front();
    end
    if (wr_go) begin
      wslot = nxt;
      mlen[nxt] = 0;
      for (int j = 0; j < DP; j++) known[nxt][j] = 1'b0;
      nxt = (nxt + 1) % NS;
      occ++;
      pend_q.push_back(wslot);
    end
    @(posedge clock);
    #1;
    wr_next = 1'b0; rd_next = 1'b0; wr_en = 1'b0;
  endtask

  task automatic check_all();
    int a;
    chk("wr_len", wr_len, (wslot < 0) ? 0 : mlen[wslot]);
    chk("rd_len", rd_len, (sel < 0) ? 0 : mlen[sel]);
    chk("full", full, occ == NS);
    chk("empty", empty, occ == 0);
    chk("done_port", done_port, pend_q.size() == 0);
    a = $urandom_range(0, DP - 1);
    rd_addr = 4'(a);
    #1;
    if (sel < 0) chk("rd_data_idle", rd_data, 0);
    else if (known[sel][a]) chk("rd_data", rd_data, mdata[sel][a]);
  endtask

  task automatic write_word(input int idx, input int val);
    wr_en = 1'b1; wr_addr = 4'(idx); wr_data = 8'(val);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_len"}, wr_len, 0);
    chk({tag, "_rd_len"}, rd_len, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_done"}, done_port, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    reset = 1'b1; start_port = 1'b0; wr_next = 1'b0; wr_en = 1'b0; rd_next = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    start_port = 1'b1;

    // First open: slot 0
    wr_next = 1'b1; tick();
    chk("open_wr_len", wr_len, 0);
    chk("open_empty", empty, 0);
    chk("open_done", done_port, 0);

    for (int i = 0; i < 8; i++) write_word(i, 100 + i);
    chk("pkt0_len", wr_len, 8);
    wr_next = 1'b1; tick();
    for (int i = 0; i < 4; i++) write_word(i, 200 + i);
    chk("pkt1_len", wr_len, 4);

    rd_next = 1'b1; tick();
    chk("rd0_len", rd_len, 8);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 4'(i); #1;
      chk("rd0_data", rd_data, 100 + i);
    end
    rd_next = 1'b1; tick();
    chk("rd1_len", rd_len, 4);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 4'(i); #1;
      chk("rd1_data", rd_data, 200 + i);
    end
    chk("rd1_done", done_port, 1);
    chk("rd1_empty", empty, 0);
    chk("rd1_full", full, 0);

    // Nothing pending: selection must hold
    rd_next = 1'b1; tick();
    chk("idle_rd_len", rd_len, 4);
    rd_addr = 4'd0; #1;
    chk("idle_rd_data", rd_data, 200);

    // Fill the ring: three opens fit, then two more pulses are dropped
    for (int i = 0; i < 3; i++) begin wr_next = 1'b1; tick(); end
    chk("fill_full", full, 1);
    write_word(2, 8'h55);
    chk("fill_wr_len", wr_len, 3);
    for (int i = 0; i < 2; i++) begin wr_next = 1'b1; tick(); end
    chk("over_full", full, 1);
    chk("over_wr_len", wr_len, 3);
    check_all();

    // Free one slot and open it, then write out of order
    rd_next = 1'b1; tick();
    chk("free_full", full, 0);
    wr_next = 1'b1; tick();
    write_word(5, 8'h11);
    chk("ooo_len_a", wr_len, 6);
    write_word(2, 8'h22);
    chk("ooo_len_b", wr_len, 6);
    check_all();

    // Asynchronous reset mid-packet, observed before any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      start_port = ($urandom_range(0, 9) != 0);
      wr_next    = ($urandom_range(0, 4) == 0);
      rd_next    = ($urandom_range(0, 4) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 4'($urandom_range(0, DP - 1));
      wr_data    = 8'($urandom_range(0, 255));
      tick();
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
